// File: rtl/mem_seq_if.sv
// Handshake/control bundle between the control unit, the memory and the
// memory-access sequencer. The master side is the control unit plus memory;
// the slave side is the sequencer itself.
interface mem_seq_if;
    // requests from the control unit
    logic       start;
    logic [1:0] op;
    logic       addr_src;
    // memory handshake
    logic       mem_ready;
    // sequencer controls and status
    logic       ar_wen;
    logic       ar_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wen;
    logic       dr_wen;
    logic       pc_inc;
    logic       busy;
    logic       done;
    logic       timeout;

    modport master (
        output start, op, addr_src, mem_ready,
        input  ar_wen, ar_sel, mem_rd, mem_wr, ir_wen, dr_wen, pc_inc,
               busy, done, timeout
    );

    modport slave (
        input  start, op, addr_src, mem_ready,
        output ar_wen, ar_sel, mem_rd, mem_wr, ir_wen, dr_wen, pc_inc,
               busy, done, timeout
    );
endinterface

// File: rtl/mem_seq.sv
// Memory-access sequencer for the 8-bit datapath: loads AR, issues one
// memory read/write, waits for mem_ready (bounded by WAIT_MAX) and steers
// returned data into IR (fetch) or DR (load).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; op/addr_src latched on acceptance
// LOAD_AR | AR written from immediate or bus (ar_sel = latched addr_src)
// REQ     | mem_rd/mem_wr asserted until mem_ready or wait limit
// WB      | returned data written to IR (+PC increment) or DR
// DONE    | one-cycle done pulse, then back to IDLE
module mem_seq #(
    parameter int WIDTH    = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic      Clk,
    input  logic      Rst,
    mem_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_AR = 3'd1,
        REQ     = 3'd2,
        WB      = 3'd3,
        DONE    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_FETCH = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    // All controls except timeout, registered together with the state so
    // that no input ever reaches an output combinationally.
    typedef struct packed {
        logic ar_wen;
        logic ar_sel;
        logic mem_rd;
        logic mem_wr;
        logic ir_wen;
        logic dr_wen;
        logic pc_inc;
        logic busy;
        logic done;
    } ctl_t;

    // Counter value seen during the last permitted wait cycle in REQ.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    // Out-of-range parameters would make the wait counter meaningless.
    if (WIDTH < 1 || WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_param_check
        $error("mem_seq: illegal WIDTH/WAIT_MAX");
    end

    state_t     state;
    op_t        op_q;
    logic       src_q;
    logic [7:0] cnt;
    ctl_t       ctl;
    logic       timeout_q;

    // Control word for a given state and latched access attributes. Called
    // with the *next* state so the registered word lines up with the state.
    function automatic ctl_t decode(input state_t s, input op_t o, input logic src);
        ctl_t c;
        c = '0;
        case (s)
            LOAD_AR: begin
                c.ar_wen = 1'b1;
                c.ar_sel = src;
                c.busy   = 1'b1;
            end
            REQ: begin
                c.mem_rd = (o != OP_STORE);
                c.mem_wr = (o == OP_STORE);
                c.busy   = 1'b1;
            end
            WB: begin
                c.ir_wen = (o == OP_FETCH);
                c.pc_inc = (o == OP_FETCH);
                c.dr_wen = (o == OP_LOAD);
                c.busy   = 1'b1;
            end
            DONE: begin
                c.done = 1'b1;
                c.busy = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Sequencer FSM: state, latched access attributes, wait counter,
    // registered controls and the sticky timeout flag.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            op_q      <= OP_FETCH;
            src_q     <= 1'b0;
            cnt       <= '0;
            ctl       <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // reserved op is dropped without touching timeout
                    if (bus.start && (op_t'(bus.op) != OP_RSVD)) begin
                        state     <= LOAD_AR;
                        op_q      <= op_t'(bus.op);
                        src_q     <= bus.addr_src;
                        cnt       <= '0;
                        timeout_q <= 1'b0;
                        ctl       <= decode(LOAD_AR, op_t'(bus.op), bus.addr_src);
                    end else begin
                        ctl <= decode(IDLE, op_q, src_q);
                    end
                end
                LOAD_AR: begin
                    state <= REQ;
                    ctl   <= decode(REQ, op_q, src_q);
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        // ready on the last allowed cycle still counts as success
                        if (op_q == OP_STORE) begin
                            state <= DONE;
                            ctl   <= decode(DONE, op_q, src_q);
                        end else begin
                            state <= WB;
                            ctl   <= decode(WB, op_q, src_q);
                        end
                    end else if (cnt == WAIT_LAST) begin
                        state     <= DONE;
                        timeout_q <= 1'b1;
                        ctl       <= decode(DONE, op_q, src_q);
                    end else begin
                        cnt <= cnt + 8'd1;
                        ctl <= decode(REQ, op_q, src_q);
                    end
                end
                WB: begin
                    state <= DONE;
                    ctl   <= decode(DONE, op_q, src_q);
                end
                DONE: begin
                    state <= IDLE;
                    ctl   <= decode(IDLE, op_q, src_q);
                end
                default: begin
                    state <= IDLE;
                    ctl   <= '0;
                end
            endcase
        end
    end

    assign bus.ar_wen  = ctl.ar_wen;
    assign bus.ar_sel  = ctl.ar_sel;
    assign bus.mem_rd  = ctl.mem_rd;
    assign bus.mem_wr  = ctl.mem_wr;
    assign bus.ir_wen  = ctl.ir_wen;
    assign bus.dr_wen  = ctl.dr_wen;
    assign bus.pc_inc  = ctl.pc_inc;
    assign bus.busy    = ctl.busy;
    assign bus.done    = ctl.done;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq: per-cycle control vectors compared against
// hand-computed constants, sampled on the falling edge.
module tb_mem_seq;

    logic Clk = 1'b0;
    logic Rst;

    mem_seq_if bus();

    mem_seq #(.WIDTH(8), .WAIT_MAX(15)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    // bit order: ar_wen ar_sel mem_rd mem_wr ir_wen dr_wen pc_inc busy done
    localparam logic [8:0] V_IDLE     = 9'b000000000;
    localparam logic [8:0] V_LDAR_IMM = 9'b110000010;
    localparam logic [8:0] V_LDAR_BUS = 9'b100000010;
    localparam logic [8:0] V_RD       = 9'b001000010;
    localparam logic [8:0] V_WR       = 9'b000100010;
    localparam logic [8:0] V_WB_IR    = 9'b000010110;
    localparam logic [8:0] V_WB_DR    = 9'b000001010;
    localparam logic [8:0] V_DONE     = 9'b000000011;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] obs();
        return {bus.ar_wen, bus.ar_sel, bus.mem_rd, bus.mem_wr, bus.ir_wen,
                bus.dr_wen, bus.pc_inc, bus.busy, bus.done};
    endfunction

    // advance one clock, then check the control vector and timeout flag
    task automatic cyc(input string tag, input logic [8:0] exp, input logic exp_to);
        @(posedge Clk);
        @(negedge Clk);
        chk(tag, 16'(obs()), 16'(exp));
        chk({tag, "_to"}, 16'(bus.timeout), 16'(exp_to));
    endtask

    initial begin
        Rst           = 1'b1;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.addr_src  = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_out", 16'(obs()), 16'(V_IDLE));
        chk("rst_to", 16'(bus.timeout), 16'd0);
        Rst = 1'b0;

        // zero-wait fetch from immediate
        bus.start = 1'b1; bus.op = 2'b00; bus.addr_src = 1'b1; bus.mem_ready = 1'b1;
        cyc("fe_k", V_LDAR_IMM, 1'b0);
        bus.start = 1'b0;
        cyc("fe_req", V_RD, 1'b0);
        cyc("fe_wb", V_WB_IR, 1'b0);
        cyc("fe_done", V_DONE, 1'b0);
        cyc("fe_idle", V_IDLE, 1'b0);

        // load from bus with 3 wait cycles; start pulse while busy is ignored
        bus.start = 1'b1; bus.op = 2'b01; bus.addr_src = 1'b0; bus.mem_ready = 1'b0;
        cyc("ld_k", V_LDAR_BUS, 1'b0);
        bus.start = 1'b0;
        cyc("ld_req1", V_RD, 1'b0);
        bus.start = 1'b1; bus.op = 2'b10; bus.addr_src = 1'b1;
        cyc("ld_req2", V_RD, 1'b0);
        bus.start = 1'b0;
        cyc("ld_req3", V_RD, 1'b0);
        cyc("ld_req4", V_RD, 1'b0);
        bus.mem_ready = 1'b1;
        cyc("ld_wb", V_WB_DR, 1'b0);
        bus.mem_ready = 1'b0;
        cyc("ld_done", V_DONE, 1'b0);
        cyc("ld_idle", V_IDLE, 1'b0);

        // store, then a start held from DONE: accepted only after one idle cycle
        bus.start = 1'b1; bus.op = 2'b10; bus.addr_src = 1'b1; bus.mem_ready = 1'b1;
        cyc("st_k", V_LDAR_IMM, 1'b0);
        bus.start = 1'b0;
        cyc("st_req", V_WR, 1'b0);
        cyc("st_done", V_DONE, 1'b0);
        bus.start = 1'b1; bus.op = 2'b10; bus.addr_src = 1'b0;
        cyc("b2b_idle", V_IDLE, 1'b0);
        cyc("b2b_k", V_LDAR_BUS, 1'b0);
        bus.start = 1'b0;
        cyc("b2b_req", V_WR, 1'b0);
        cyc("b2b_done", V_DONE, 1'b0);
        cyc("b2b_idle2", V_IDLE, 1'b0);

        // timeout: mem_ready never high, REQ lasts exactly 15 cycles
        bus.start = 1'b1; bus.op = 2'b00; bus.addr_src = 1'b0; bus.mem_ready = 1'b0;
        cyc("to_k", V_LDAR_BUS, 1'b0);
        bus.start = 1'b0;
        for (int i = 1; i <= 15; i++) cyc($sformatf("to_req%0d", i), V_RD, 1'b0);
        cyc("to_done", V_DONE, 1'b1);
        cyc("to_idle", V_IDLE, 1'b1);

        // reserved op in IDLE: ignored, sticky timeout untouched
        bus.start = 1'b1; bus.op = 2'b11; bus.addr_src = 1'b1;
        cyc("rsvd1", V_IDLE, 1'b1);
        cyc("rsvd2", V_IDLE, 1'b1);
        bus.start = 1'b0;

        // boundary: ready on REQ cycle 15 is success; start clears timeout
        bus.start = 1'b1; bus.op = 2'b01; bus.addr_src = 1'b1;
        cyc("bd_k", V_LDAR_IMM, 1'b0);
        bus.start = 1'b0;
        for (int i = 1; i <= 15; i++) cyc($sformatf("bd_req%0d", i), V_RD, 1'b0);
        bus.mem_ready = 1'b1;
        cyc("bd_wb", V_WB_DR, 1'b0);
        bus.mem_ready = 1'b0;
        cyc("bd_done", V_DONE, 1'b0);
        cyc("bd_idle", V_IDLE, 1'b0);

        // asynchronous reset in the middle of REQ; no done afterwards
        bus.start = 1'b1; bus.op = 2'b00; bus.addr_src = 1'b1;
        cyc("rs_k", V_LDAR_IMM, 1'b0);
        bus.start = 1'b0;
        cyc("rs_req1", V_RD, 1'b0);
        cyc("rs_req2", V_RD, 1'b0);
        #2 Rst = 1'b1;
        #1;
        chk("rs_async", 16'(obs()), 16'(V_IDLE));
        chk("rs_async_to", 16'(bus.timeout), 16'd0);
        @(negedge Clk);
        Rst = 1'b0;
        bus.mem_ready = 1'b1;
        cyc("rs_after1", V_IDLE, 1'b0);
        cyc("rs_after2", V_IDLE, 1'b0);

        // clean fetch after reset
        bus.start = 1'b1; bus.op = 2'b00; bus.addr_src = 1'b0;
        cyc("cf_k", V_LDAR_BUS, 1'b0);
        bus.start = 1'b0;
        cyc("cf_req", V_RD, 1'b0);
        cyc("cf_wb", V_WB_IR, 1'b0);
        cyc("cf_done", V_DONE, 1'b0);
        cyc("cf_idle", V_IDLE, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/mem_seq.md
# mem_seq

Memory-access sequencer for the 8-bit processor datapath. It generates the load controls of the address register AR (write enable plus the immediate/bus source select), issues a memory read or write against the addressed location, and waits for a ready handshake. It then steers returned data into the instruction register (IR) or data register (DR). The control unit issues a single `start` pulse per access and sees `busy`, `done` and `timeout` in return.

## Interface
- `WIDTH`, default 8: datapath width; carried for consistency with the datapath registers, no internal data path.
- `WAIT_MAX`, default 15: maximum REQ cycles before timeout; legal range 1..255.

- `Clk`  in  1  system clock, rising-edge active.
- `Rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  access request, sampled only in IDLE.
- `op`  in  2  access type: 00 fetch, 01 load, 10 store, 11 reserved.
- `addr_src`  in  1  AR source: 1 = immediate (IOut), 0 = bus (BusOut).
- `mem_ready`  in  1  memory handshake; high means data valid (read) or write accepted.
- `ar_wen`  out  1  AR write enable.
- `ar_sel`  out  1  AR source select (selAR).
- `mem_rd`  out  1  memory read request.
- `mem_wr`  out  1  memory write request.
- `ir_wen`  out  1  IR write enable.
- `dr_wen`  out  1  DR write enable.
- `pc_inc`  out  1  program-counter increment pulse.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `timeout`  out  1  error flag for the last access; sticky.

## Operation
- **States:** IDLE, LOAD_AR, REQ, WB, DONE. State is registered.
- **Output decode:** outputs other than `timeout` decode from state plus the latched `op`/`addr_src` only. No combinational path from any input to any output.
- **IDLE → LOAD_AR:** taken when `start`=1 and `op`≠11. At that edge, `op` and `addr_src` are latched, `timeout` is cleared and the wait counter is zeroed.
- **IDLE, no transition:** `start` with `op`=11 is ignored; state and `timeout` are unchanged.
- **LOAD_AR:** `ar_wen`=1 and `ar_sel`=latched `addr_src`. Always goes to REQ next cycle.
- **REQ:** `mem_rd`=1 for fetch/load; `mem_wr`=1 for store.
  - `mem_ready`=1: fetch/load → WB; store → DONE.
  - `mem_ready`=0: the counter increments. When the counter reaches WAIT_MAX-1 with `mem_ready`=0, the next state is DONE and `timeout` is set.
  - `mem_ready` high on the WAIT_MAX-th REQ cycle is a success, not a timeout.
- **WB:**
  - fetch: `ir_wen`=1 and `pc_inc`=1.
  - load: `dr_wen`=1.
  - Always goes to DONE.
- **DONE:** `done`=1, then IDLE.
- **Ignored inputs:** `start` is ignored while `busy`. `mem_ready` is ignored outside REQ.
- **Exclusivity:** `mem_rd` and `mem_wr` are never high together. At most one of `ar_wen`, `ir_wen`, `dr_wen` is high in any cycle.
- **Counter:** 8 bits, saturating is not required because the range is bounded by WAIT_MAX.
- **Reset (any time, including mid-access):** state IDLE, all outputs 0, `timeout`=0, counter 0, latched `op`=00, latched `addr_src`=0. An access interrupted by reset is abandoned; no `done` pulse.

## Timing
Edge k is the rising edge at which `start` is sampled in IDLE.
- LOAD_AR occupies cycle k..k+1; AR captures its source on edge k+1.
- REQ starts at edge k+1.
- Fetch/load with `mem_ready`=1 in the first REQ cycle: WB at edge k+2, DONE at edge k+3, IDLE at edge k+4. `busy` is high for 4 cycles.
- Store with `mem_ready`=1 in the first REQ cycle: DONE at edge k+2, IDLE at edge k+3. `busy` is high for 3 cycles.
- Each cycle of `mem_ready`=0 in REQ adds one cycle.
- Timeout path: REQ lasts exactly WAIT_MAX cycles, then DONE with `done`=1 and `timeout`=1. No WB occurs. `timeout` stays high until the next accepted `start`.
- A new `start` may be accepted on the edge at which the block has just returned to IDLE. Back-to-back accesses therefore have one idle cycle minimum.

## Test plan
- **Reset mid-REQ:** assert `Rst` while waiting → all outputs 0 immediately (asynchronous). No `done` follows. After release, `start` with `op`=00 begins a clean fetch.
- **Zero-wait fetch:** `op`=00, `addr_src`=1, `mem_ready` tied high → `ar_wen`=`ar_sel`=1 at cycle k, `mem_rd` at k+1, `ir_wen`=`pc_inc`=1 at k+2, `done` at k+3.
- **Load with 3 wait cycles:** `op`=01, `addr_src`=0, `mem_ready` low 3 cycles then high → `ar_sel`=0; `mem_rd` high 4 cycles; `dr_wen` one cycle; `ir_wen`/`pc_inc` never high.
- **Store:** `op`=10, `mem_ready` high → `mem_wr` 1 cycle, no WB. `done` at k+2; `busy` high exactly 3 cycles.
- **Timeout and boundary, WAIT_MAX=15:**
  - `mem_ready` never high → `mem_rd` high exactly 15 cycles, then `done`=1 with `timeout`=1; `timeout` remains set through IDLE.
  - Next accepted start clears `timeout`.
  - Repeat with `mem_ready` high on REQ cycle 15 → success, `timeout`=0.
- **Ignored requests:** `start` pulses while `busy`, and `start` with `op`=11 in IDLE → no state change; outputs unaffected.
